// File: rtl/elastic_alu_pipe.sv
// Three-stage elastic ALU pipeline computing q = (a OP1 b) OP2 c with valid/ready flow
// control, synchronous flush, carry/borrow flag and a wrapping completed-transfer counter.
module elastic_alu_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [2:0]       op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q_out,
    output logic             carry_out,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        OP2_XOR  = 2'b00,
        OP2_AND  = 2'b01,
        OP2_OR   = 2'b10,
        OP2_PASS = 2'b11
    } op2_e;

    logic             v1, v2, v3;
    logic [WIDTH-1:0] a1, b1, c1, c2, q3;
    logic [2:0]       op1;
    op2_e             op2;
    logic [WIDTH:0]   s2;
    logic             cy3;
    logic [CNT_W-1:0] cnt;

    logic             adv1, adv2, adv3;
    logic             fire;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   s_next;
    logic [WIDTH-1:0] q_next;

    // A stage may take new data when it is empty or its successor is moving, so bubbles
    // collapse even while the output is stalled.
    assign adv3      = out_ready | ~v3;
    assign adv2      = adv3 | ~v2;
    assign adv1      = adv2 | ~v1;
    assign in_ready  = adv1 & ~flush;
    assign fire      = v3 & out_ready;

    assign out_valid = v3;
    assign q_out     = q3;
    assign carry_out = cy3;
    assign xfer_cnt  = cnt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sum    = '0;
        s_next = '0;
        if (op1[0]) begin
            // Subtraction as a + ~b + 1; the stored MSB is the borrow, i.e. the inverted carry.
            sum    = {1'b0, a1} + {1'b0, ~b1} + {{WIDTH{1'b0}}, 1'b1};
            s_next = {~sum[WIDTH], sum[WIDTH-1:0]};
        end else begin
            s_next = {1'b0, a1} + {1'b0, b1};
        end
    end

    always_comb begin
        q_next = s2[WIDTH-1:0];
        unique case (op2)
            OP2_XOR:  q_next = s2[WIDTH-1:0] ^ c2;
            OP2_AND:  q_next = s2[WIDTH-1:0] & c2;
            OP2_OR:   q_next = s2[WIDTH-1:0] | c2;
            OP2_PASS: q_next = s2[WIDTH-1:0];
            default:  q_next = s2[WIDTH-1:0];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            c1  <= '0;
            op1 <= '0;
            s2  <= '0;
            c2  <= '0;
            op2 <= OP2_XOR;
            q3  <= '0;
            cy3 <= 1'b0;
            cnt <= '0;
        end else begin
            if (fire) begin
                cnt <= cnt + 1'b1;
            end
            // Flush drops every valid bit but leaves the data registers as they were.
            if (flush) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
                v3 <= 1'b0;
            end else begin
                if (adv1) begin
                    v1 <= in_valid;
                    if (in_valid) begin
                        a1  <= a_in;
                        b1  <= b_in;
                        c1  <= c_in;
                        op1 <= op_in;
                    end
                end
                if (adv2) begin
                    v2 <= v1;
                    if (v1) begin
                        s2  <= s_next;
                        c2  <= c1;
                        op2 <= op2_e'(op1[2:1]);
                    end
                end
                if (adv3) begin
                    v3 <= v2;
                    if (v2) begin
                        q3  <= q_next;
                        cy3 <= s2[WIDTH];
                    end
                end
            end
        end
    end

endmodule
